// File: rtl/key_scan_ctrl.sv
// Round-robin debounce controller: one shared saturating integrator with
// hysteresis visits each key per scan slot; edges are queued in an event FIFO.
module key_scan_ctrl #(
  parameter  int unsigned N_KEYS     = 8,
  parameter  int unsigned CNT_W      = 8,
  parameter  int unsigned HI_TH      = 192,
  parameter  int unsigned LO_TH      = 64,
  parameter  int unsigned TICK_DIV   = 64,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned IDX_W      = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] toggle_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_toggle,
  output logic              ev_valid,
  output logic [IDX_W:0]    ev_data,
  input  logic              ev_ready,
  output logic              ev_overflow,
  input  logic              ovf_clr
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   HI_V      = (CNT_W+1)'(HI_TH);
  localparam logic [CNT_W:0]   LO_V      = (CNT_W+1)'(LO_TH);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_KEYS - 1);
  localparam logic [PW:0]      FIFO_FULL = (PW+1)'(FIFO_DEPTH);

  logic [N_KEYS-1:0]                r_sync1;
  logic [N_KEYS-1:0]                r_sync2;
  logic [TW-1:0]                    r_tick;
  logic [IDX_W-1:0]                 r_idx;
  logic [N_KEYS-1:0][CNT_W-1:0]     r_cnt;
  logic [N_KEYS-1:0]                r_level;
  logic [N_KEYS-1:0]                r_tog;
  logic                             r_ovf;
  logic [FIFO_DEPTH-1:0][IDX_W:0]   r_mem;
  logic [PW:0]                      r_wptr;
  logic [PW:0]                      r_rptr;

  logic             w_slot;
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_upd;
  logic             w_key;
  logic             w_lvl;
  logic             w_rise;
  logic             w_fall;
  logic             w_push;
  logic [IDX_W:0]   w_ev;
  logic [PW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;

  always_comb begin
    w_slot = (r_tick == TICK_LAST);
    w_cur  = r_cnt[r_idx];
    w_key  = r_sync2[r_idx];
    w_lvl  = r_level[r_idx];
    if (w_key) w_upd = (w_cur == CNT_MAX) ? w_cur : w_cur + 1'b1;
    else       w_upd = (w_cur == '0)      ? w_cur : w_cur - 1'b1;
    w_rise  = w_slot & ~w_lvl & ({1'b0, w_upd} >= HI_V);
    w_fall  = w_slot &  w_lvl & ({1'b0, w_upd} <  LO_V);
    w_push  = w_rise | w_fall;
    w_ev    = {w_rise, r_idx};
    w_count = r_wptr - r_rptr;
    w_empty = (w_count == '0);
    w_full  = (w_count == FIFO_FULL);
    w_pop   = ~w_empty & ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_wr    = w_push & (~w_full | w_pop);
    w_drop  = w_push & w_full & ~w_pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_tick  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_level <= '0;
      r_tog   <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (w_slot) begin
        r_tick       <= '0;
        r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        r_cnt[r_idx] <= w_upd;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
      if (w_rise) begin
        r_level[r_idx] <= 1'b1;
        if (toggle_en[r_idx]) r_tog[r_idx] <= ~r_tog[r_idx];
      end
      if (w_fall) r_level[r_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[PW-1:0]] <= w_ev;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    key_level   = r_level;
    key_toggle  = (toggle_en & r_tog) | (~toggle_en & r_level);
    ev_valid    = ~w_empty;
    ev_data     = w_empty ? '0 : r_mem[r_rptr[PW-1:0]];
    ev_overflow = r_ovf;
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: cycle-level reference model plus directed scenarios
// with hand-computed expectations at known slot edges.
module tb_key_scan_ctrl;

  localparam int N_KEYS     = 4;
  localparam int CNT_W      = 3;
  localparam int HI_TH      = 3;
  localparam int LO_TH      = 1;
  localparam int TICK_DIV   = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 2;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_KEYS-1:0] key_in = '0;
  logic [N_KEYS-1:0] toggle_en = '0;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_toggle;
  logic              ev_valid;
  logic [IDX_W:0]    ev_data;
  logic              ev_ready = 1'b0;
  logic              ev_overflow;
  logic              ovf_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  key_scan_ctrl #(
    .N_KEYS(N_KEYS), .CNT_W(CNT_W), .HI_TH(HI_TH), .LO_TH(LO_TH),
    .TICK_DIV(TICK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .toggle_en(toggle_en),
    .key_level(key_level), .key_toggle(key_toggle), .ev_valid(ev_valid),
    .ev_data(ev_data), .ev_ready(ev_ready), .ev_overflow(ev_overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: integer counts per key, event queue, slot counter.
  int                m_cnt [N_KEYS];
  bit                m_lvl [N_KEYS];
  bit                m_tog [N_KEYS];
  bit [N_KEYS-1:0]   m_s1, m_s2;
  int                m_q [$];
  bit                m_ovf;
  int                m_tick, m_idx;

  always @(posedge clk or negedge rst) begin
    bit pop, push, drop;
    int ev, k, c;
    if (!rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        m_cnt[i] = 0; m_lvl[i] = 0; m_tog[i] = 0;
      end
      m_s1 = '0; m_s2 = '0; m_q.delete(); m_ovf = 0; m_tick = 0; m_idx = 0;
    end else begin
      pop  = (m_q.size() > 0) && ev_ready;
      push = 0;
      drop = 0;
      ev   = 0;
      if (m_tick == TICK_DIV - 1) begin
        k = m_idx;
        c = m_cnt[k];
        if (m_s2[k]) c = (c < CMAX) ? c + 1 : CMAX;
        else         c = (c > 0) ? c - 1 : 0;
        m_cnt[k] = c;
        if (c >= HI_TH && !m_lvl[k]) begin
          m_lvl[k] = 1; push = 1; ev = (1 << IDX_W) + k;
          if (toggle_en[k]) m_tog[k] = !m_tog[k];
        end else if (c < LO_TH && m_lvl[k]) begin
          m_lvl[k] = 0; push = 1; ev = k;
        end
        m_idx  = (m_idx + 1) % N_KEYS;
        m_tick = 0;
      end else begin
        m_tick++;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(ev);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N_KEYS-1:0] e_lvl, e_tog;
    #2;
    for (int i = 0; i < N_KEYS; i++) begin
      e_lvl[i] = m_lvl[i];
      e_tog[i] = toggle_en[i] ? m_tog[i] : m_lvl[i];
    end
    check("model key_level", 32'(key_level), 32'(e_lvl));
    check("model key_toggle", 32'(key_toggle), 32'(e_tog));
    check("model ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
    check("model ev_data", 32'(ev_data), (m_q.size() > 0) ? m_q[0] : 0);
    check("model ev_overflow", 32'(ev_overflow), 32'(m_ovf));
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N_KEYS-1:0] keys);
    @(negedge clk);
    #3;
    rst = 1'b0;
    key_in = keys;
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (10) @(negedge clk);
    check("rst key_level", 32'(key_level), 0);
    check("rst key_toggle", 32'(key_toggle), 0);
    check("rst ev_valid", 32'(ev_valid), 0);
    check("rst ev_data", 32'(ev_data), 0);
    check("rst ev_overflow", 32'(ev_overflow), 0);
    rst = 1'b1;
  endtask

  initial begin
    // Reset with all keys high; then fill FIFO and push+pop while full.
    do_reset(4'b1111);
    wait_edges(10);
    check("t1 level before cross", 32'(key_level), 0);
    wait_edges(1);
    check("t1 key2 rises", 32'(key_level), 32'b0100);
    check("t1 first event", 32'(ev_data), 32'b110);
    key_in[2] = 1'b0;
    wait_edges(3);
    check("t6 all levels", 32'(key_level), 32'b1111);
    check("t6 fifo valid", 32'(ev_valid), 1);
    wait_edges(8);
    check("t6 key2 still high", 32'(key_level), 32'b1111);
    ev_ready = 1'b1;
    wait_edges(1);
    check("t6 no overflow", 32'(ev_overflow), 0);
    check("t6 key2 fell", 32'(key_level), 32'b1011);
    check("t6 head after pop", 32'(ev_data), 32'b111);
    wait_edges(1);
    check("t6 drain 2", 32'(ev_data), 32'b100);
    wait_edges(1);
    check("t6 drain 3", 32'(ev_data), 32'b101);
    wait_edges(1);
    check("t6 drain 4", 32'(ev_data), 32'b010);
    wait_edges(1);
    check("t6 empty", 32'(ev_valid), 0);

    // Single key press/release, reset discarding queued state.
    key_in[2] = 1'b1;
    ev_ready = 1'b0;
    wait_edges(20);
    do_reset(4'b0100);
    wait_edges(10);
    check("t2 level before cross", 32'(key_level), 0);
    wait_edges(1);
    check("t2 key2 rises", 32'(key_level), 32'b0100);
    check("t2 press event", 32'(ev_data), 32'b110);
    key_in = '0;
    wait_edges(11);
    check("t2 still high", 32'(key_level), 32'b0100);
    wait_edges(1);
    check("t2 release", 32'(key_level), 0);
    ev_ready = 1'b1;
    wait_edges(1);
    check("t2 release event", 32'(ev_data), 32'b010);
    wait_edges(1);
    check("t2 empty", 32'(ev_valid), 0);

    // Bounce inside hysteresis band, then saturation at both ends.
    do_reset(4'b0001);
    wait_edges(8);
    for (int i = 0; i < 10; i++) begin
      key_in[0] = ~key_in[0];
      wait_edges(4);
    end
    check("t3 band no level", 32'(key_level), 0);
    check("t3 band no event", 32'(ev_valid), 0);
    ev_ready = 1'b1;
    key_in = 4'b0001; wait_edges(48);
    check("t3 sat high level", 32'(key_level), 32'b0001);
    key_in = 4'b0000; wait_edges(96);
    check("t3 sat low level", 32'(key_level), 0);
    key_in = 4'b0001; wait_edges(48);

    // Toggle mode on key 1.
    toggle_en = 4'b0010;
    do_reset(4'b0000);
    ev_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      key_in[1] = 1'b1; wait_edges(48);
      check("t4 toggle pressed", 32'(key_toggle[1]), (p % 2 == 0) ? 1 : 0);
      key_in[1] = 1'b0; wait_edges(48);
      check("t4 toggle released", 32'(key_toggle[1]), (p % 2 == 0) ? 1 : 0);
    end
    toggle_en = 4'b0000;
    #1;
    check("t4 follow level low", 32'(key_toggle[1]), 0);
    key_in[1] = 1'b1; wait_edges(48);
    check("t4 follow level high", 32'(key_toggle[1]), 1);

    // Overflow: five events into a four-entry FIFO.
    do_reset(4'b0000);
    key_in = 4'b0001; wait_edges(48);
    key_in = 4'b0000; wait_edges(48);
    key_in = 4'b0010; wait_edges(48);
    key_in = 4'b0000; wait_edges(48);
    key_in = 4'b0100; wait_edges(48);
    check("t5 overflow set", 32'(ev_overflow), 1);
    check("t5 head", 32'(ev_data), 32'b100);
    ovf_clr = 1'b1; wait_edges(1); ovf_clr = 1'b0;
    check("t5 overflow cleared", 32'(ev_overflow), 0);
    ev_ready = 1'b1;
    wait_edges(1);
    check("t5 drain 2", 32'(ev_data), 32'b000);
    wait_edges(1);
    check("t5 drain 3", 32'(ev_data), 32'b101);
    wait_edges(1);
    check("t5 drain 4", 32'(ev_data), 32'b001);
    wait_edges(1);
    check("t5 empty", 32'(ev_valid), 0);
    wait_edges(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
